ex_resolve_stage: RTL and testbench
===================================

Name: ex_resolve_stage

Overview:
- Consumer end of the ALU output channel.
- Takes ALU valid/result/branch outcome plus decode sideband, then registers it into the EX/MEM pipeline register.
- Resolves branches against the fetch-time prediction and issues a one-cycle recovery redirect to fetch.
- Keeps branch/mispredict counters and sticky pass/done/fail status from customized MTC0 instructions.

Parameters:
DATA_WIDTH, 32, width of ALU result and pipeline data
ADDR_WIDTH, 32, width of PC/target addresses
CNT_WIDTH, 32, width of branch and mispredict counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU output valid
alu_result  in  DATA_WIDTH  ALU result
alu_branch_outcome  in  1  1=TAKEN, 0=NOT_TAKEN
is_branch  in  1  instruction is a conditional/unconditional branch
predicted_taken  in  1  fetch-time prediction for this branch
branch_target  in  ADDR_WIDTH  taken-path address
pc_plus8  in  ADDR_WIDTH  fall-through address
rw_en  in  1  instruction writes a register
rw_addr  in  5  destination register
mtc0_code  in  2  00 none, 01 PASS, 10 DONE, 11 FAIL
stall  in  1  MEM stage cannot accept; hold register
flush  in  1  squash the instruction currently presented
mem_valid  out  1  EX/MEM register valid
mem_result  out  DATA_WIDTH  registered result
mem_rw_en  out  1  registered write enable, qualified by mem_valid
mem_rw_addr  out  5  registered destination
recover_valid  out  1  one-cycle redirect pulse
recover_target  out  ADDR_WIDTH  redirect address
branch_count  out  CNT_WIDTH  resolved branches
mispredict_count  out  CNT_WIDTH  mispredicted branches
pass_o, done_o, fail_o  out  1 each  sticky MTC0 status

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-stall):
  - All outputs and registers go to 0: mem_*, recover_*, counters, sticky flags.
  - Release is synchronous to clk.
- Accept condition: accept = alu_valid & ~stall & ~flush.
- Per-edge priority: reset > flush > stall > load.
- Flush:
  - mem_valid <= 0 and mem_rw_en <= 0, even if stall is high.
  - Presented instruction is dropped: no redirect, no counting, no status update.
- Stall without flush: all mem_* registers hold; the presented instruction is not accepted.
- Load:
  - On accept, mem_valid <= 1 and mem_result, mem_rw_en, mem_rw_addr <= inputs.
  - When alu_valid=0 and no stall, mem_valid <= 0 (bubble).
- Latency: 1 cycle from accept edge to mem_valid and to recover_valid.
- Mispredict:
  - mispredict = is_branch & (alu_branch_outcome != predicted_taken), evaluated only on accept.
  - On accept with mispredict: recover_valid <= 1 for exactly one cycle.
  - recover_target <= alu_branch_outcome ? branch_target : pc_plus8.
  - Otherwise recover_valid <= 0; recover_target holds its last value.
  - Because redirect is tied to accept, a stalled branch redirects exactly once, on the cycle it is finally accepted.
- Counters:
  - branch_count += 1 on accept & is_branch.
  - mispredict_count += 1 on accept & mispredict.
  - Both wrap modulo 2^CNT_WIDTH.
  - mispredict_count <= branch_count always holds until wrap.
- MTC0 status, on accept only:
  - 01 sets pass_o; 10 sets done_o; 11 sets fail_o.
  - Flags are sticky until reset; setting one never clears another.
  - An MTC0 instruction with rw_en=0 still passes through the pipeline register as a valid non-writing instruction.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset mid-operation: accept a mispredicted BEQ (predicted_taken=1, outcome=0, pc_plus8=0x0040_0010), then drop rst_n asynchronously before the next edge -> recover_valid, mem_valid, counters and flags all 0 immediately; no pulse after release.
- Back-to-back ALU ops: ADD result 0x0000_0005 to r3, then SUB result 0xFFFF_FFFF to r4, no stall -> mem_valid=1 one cycle after each, mem_result 5 then 0xFFFF_FFFF, mem_rw_addr 3 then 4; recover_valid stays 0.
- Mispredict: BNE predicted_taken=0, outcome TAKEN, branch_target=0x0040_0100 -> next cycle recover_valid=1 and recover_target=0x0040_0100 for one cycle only; branch_count=1, mispredict_count=1.
- Stall then accept: mispredicted branch held with stall=1 for 3 cycles, then released -> recover_valid pulses exactly once, on the cycle after release; mem_* hold prior values during the stall; counts incremented once.
- Flush vs stall: alu_valid=1, branch mispredicted, stall=1 and flush=1 together -> mem_valid=0 next cycle, no redirect, counters unchanged.
- MTC0 sequence PASS, DONE, FAIL, plus 2^CNT_WIDTH branches with a reduced CNT_WIDTH=4 build -> pass_o/done_o/fail_o all 1 and sticky; branch_count wraps 15 -> 0.

Source files
------------

// File: rtl/ex_resolve_stage.sv
// ex_resolve_stage: EX/MEM pipeline register with branch resolution, recovery redirect,
// branch/mispredict counters and sticky MTC0 pass/done/fail status.
module ex_resolve_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_branch_outcome,
  input  logic                  is_branch,
  input  logic                  predicted_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [ADDR_WIDTH-1:0] pc_plus8,
  input  logic                  rw_en,
  input  logic [4:0]            rw_addr,
  input  logic [1:0]            mtc0_code,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic                  mem_rw_en,
  output logic [4:0]            mem_rw_addr,
  output logic                  recover_valid,
  output logic [ADDR_WIDTH-1:0] recover_target,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count,
  output logic                  pass_o,
  output logic                  done_o,
  output logic                  fail_o
);
  logic accept, mispredict;
  always_comb begin
    accept     = alu_valid & ~stall & ~flush;
    mispredict = is_branch & (alu_branch_outcome != predicted_taken);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_rw_en        <= 1'b0;
      mem_rw_addr      <= '0;
      recover_valid    <= 1'b0;
      recover_target   <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      pass_o           <= 1'b0;
      done_o           <= 1'b0;
      fail_o           <= 1'b0;
    end else begin
      if (flush) begin
        mem_valid <= 1'b0;
        mem_rw_en <= 1'b0;
      end else if (!stall) begin
        mem_valid <= alu_valid;
        mem_rw_en <= alu_valid & rw_en;
        if (alu_valid) begin
          mem_result  <= alu_result;
          mem_rw_addr <= rw_addr;
        end
      end
      // Redirect and bookkeeping fire only on accept, so a stalled branch counts once.
      recover_valid <= accept & mispredict;
      if (accept & mispredict) begin
        recover_target   <= alu_branch_outcome ? branch_target : pc_plus8;
        mispredict_count <= mispredict_count + 1'b1;
      end
      if (accept & is_branch) branch_count <= branch_count + 1'b1;
      if (accept & (mtc0_code == 2'b01)) pass_o <= 1'b1;
      if (accept & (mtc0_code == 2'b10)) done_o <= 1'b1;
      if (accept & (mtc0_code == 2'b11)) fail_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_resolve_stage.sv
// tb_ex_resolve_stage: directed plus random stimulus against a behavioural model, CNT_WIDTH=4 build.
module tb_ex_resolve_stage;
  logic        clk = 0, rst_n = 0;
  logic        alu_valid = 0, alu_branch_outcome = 0, is_branch = 0, predicted_taken = 0;
  logic [31:0] alu_result = 0, branch_target = 0, pc_plus8 = 0;
  logic        rw_en = 0, stall = 0, flush = 0;
  logic [4:0]  rw_addr = 0;
  logic [1:0]  mtc0_code = 0;
  logic        mem_valid, mem_rw_en, recover_valid, pass_o, done_o, fail_o;
  logic [31:0] mem_result, recover_target;
  logic [4:0]  mem_rw_addr;
  logic [3:0]  branch_count, mispredict_count;

  ex_resolve_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_result(alu_result),
    .alu_branch_outcome(alu_branch_outcome), .is_branch(is_branch),
    .predicted_taken(predicted_taken), .branch_target(branch_target), .pc_plus8(pc_plus8),
    .rw_en(rw_en), .rw_addr(rw_addr), .mtc0_code(mtc0_code), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rw_en(mem_rw_en),
    .mem_rw_addr(mem_rw_addr), .recover_valid(recover_valid), .recover_target(recover_target),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .pass_o(pass_o), .done_o(done_o), .fail_o(fail_o));

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  bit m_v, m_rwen, m_rv, m_p, m_d, m_f;
  logic [31:0] m_res, m_rt;
  logic [4:0] m_addr;
  int m_bc, m_mc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_v = 0; m_rwen = 0; m_rv = 0; m_p = 0; m_d = 0; m_f = 0;
    m_res = 0; m_rt = 0; m_addr = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(m_v));
    chk({tag, ".mem_result"}, 64'(mem_result), 64'(m_res));
    chk({tag, ".mem_rw_en"}, 64'(mem_rw_en), 64'(m_rwen));
    chk({tag, ".mem_rw_addr"}, 64'(mem_rw_addr), 64'(m_addr));
    chk({tag, ".recover_valid"}, 64'(recover_valid), 64'(m_rv));
    chk({tag, ".recover_target"}, 64'(recover_target), 64'(m_rt));
    chk({tag, ".branch_count"}, 64'(branch_count), 64'(m_bc % 16));
    chk({tag, ".mispredict_count"}, 64'(mispredict_count), 64'(m_mc % 16));
    chk({tag, ".flags"}, 64'({pass_o, done_o, fail_o}), 64'({m_p, m_d, m_f}));
  endtask

  // One clock: the model applies the pipeline rules to the instruction on the inputs.
  task automatic tick(input string tag);
    bit acc, wrong;
    @(posedge clk);
    acc   = alu_valid && !stall && !flush;
    wrong = is_branch && (alu_branch_outcome != predicted_taken);
    if (flush) begin m_v = 0; m_rwen = 0; end
    else if (!stall) begin
      m_v = alu_valid;
      m_rwen = alu_valid && rw_en;
      if (alu_valid) begin m_res = alu_result; m_addr = rw_addr; end
    end
    m_rv = acc && wrong;
    if (m_rv) m_rt = alu_branch_outcome ? branch_target : pc_plus8;
    if (acc && is_branch) m_bc = (m_bc + 1) % 16;
    if (acc && wrong) m_mc = (m_mc + 1) % 16;
    if (acc && mtc0_code == 2'b01) m_p = 1;
    if (acc && mtc0_code == 2'b10) m_d = 1;
    if (acc && mtc0_code == 2'b11) m_f = 1;
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    alu_valid = 0; alu_result = 0; alu_branch_outcome = 0; is_branch = 0; predicted_taken = 0;
    branch_target = 0; pc_plus8 = 0; rw_en = 0; rw_addr = 0; mtc0_code = 0; stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic branch(input bit pred, input bit out, input logic [31:0] bt, input logic [31:0] p8);
    alu_valid = 1; is_branch = 1; predicted_taken = pred; alu_branch_outcome = out;
    branch_target = bt; pc_plus8 = p8; rw_en = 0; alu_result = $urandom;
  endtask

  initial begin
    idle();
    model_reset();
    #3;
    check_all("por");
    do_reset();
    // back-to-back ALU ops
    alu_valid = 1; alu_result = 32'h5; rw_en = 1; rw_addr = 3;
    tick("add");
    chk("add.result", 64'(mem_result), 64'h5);
    chk("add.addr", 64'(mem_rw_addr), 64'd3);
    alu_result = 32'hFFFF_FFFF; rw_addr = 4;
    tick("sub");
    chk("sub.result", 64'(mem_result), 64'hFFFF_FFFF);
    chk("sub.valid", 64'(mem_valid), 64'd1);
    idle();
    tick("bubble");
    chk("bubble.valid", 64'(mem_valid), 64'd0);
    // mispredicted BNE, taken
    do_reset();
    branch(0, 1, 32'h0040_0100, 32'h0040_0008);
    tick("bne");
    chk("bne.rv", 64'(recover_valid), 64'd1);
    chk("bne.rt", 64'(recover_target), 64'h0040_0100);
    chk("bne.counts", 64'({branch_count, mispredict_count}), 64'h11);
    idle();
    tick("bne_after");
    chk("bne.pulse_once", 64'(recover_valid), 64'd0);
    // stall then accept
    alu_valid = 1; alu_result = 32'h77; rw_en = 1; rw_addr = 9;
    tick("pre_stall");
    branch(1, 0, 32'h0040_0200, 32'h0040_0020);
    stall = 1;
    repeat (3) begin
      tick("stall");
      chk("stall.hold_result", 64'(mem_result), 64'h77);
      chk("stall.no_rv", 64'(recover_valid), 64'd0);
    end
    stall = 0;
    tick("release");
    chk("release.rv", 64'(recover_valid), 64'd1);
    chk("release.rt", 64'(recover_target), 64'h0040_0020);
    chk("release.bc", 64'(branch_count), 64'd2);
    idle();
    tick("release_after");
    chk("release.pulse_once", 64'(recover_valid), 64'd0);
    // flush with stall
    branch(0, 1, 32'h0040_0300, 32'h0040_0030);
    stall = 1; flush = 1;
    tick("flush");
    chk("flush.valid", 64'(mem_valid), 64'd0);
    chk("flush.rv", 64'(recover_valid), 64'd0);
    chk("flush.mc", 64'(mispredict_count), 64'd2);
    idle();
    // MTC0 status and counter wrap
    do_reset();
    alu_valid = 1; rw_en = 0;
    mtc0_code = 2'b01; tick("pass");
    mtc0_code = 2'b10; tick("done");
    mtc0_code = 2'b11; tick("fail");
    chk("mtc0.flags", 64'({pass_o, done_o, fail_o}), 64'b111);
    chk("mtc0.valid_nowrite", 64'({mem_valid, mem_rw_en}), 64'b10);
    mtc0_code = 0;
    for (int i = 0; i < 15; i++) begin
      branch(1, 1, 32'h0040_0400, 32'h0040_0040);
      tick("wrap");
    end
    chk("wrap.bc15", 64'(branch_count), 64'd15);
    tick("wrap16");
    chk("wrap.bc0", 64'(branch_count), 64'd0);
    chk("wrap.sticky", 64'({pass_o, done_o, fail_o}), 64'b111);
    idle();
    // random traffic
    for (int i = 0; i < 300; i++) begin
      alu_valid = $urandom_range(0, 3) != 0;
      alu_result = $urandom;
      is_branch = $urandom_range(0, 1);
      predicted_taken = $urandom_range(0, 1);
      alu_branch_outcome = $urandom_range(0, 1);
      branch_target = $urandom;
      pc_plus8 = $urandom;
      rw_en = $urandom_range(0, 1);
      rw_addr = 5'($urandom);
      mtc0_code = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 7) == 0;
      tick("rand");
    end
    idle();
    // asynchronous reset right after a mispredicted BEQ is accepted
    tick("pre_beq");
    branch(1, 0, 32'h0040_0500, 32'h0040_0010);
    tick("beq");
    chk("beq.rt", 64'(recover_target), 64'h0040_0010);
    idle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    tick("post_rst");
    chk("post_rst.no_rv", 64'(recover_valid), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
